// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The checksum option (IMEM_LOADER_CHECKSUM_EN) uses the CHECK state defined here.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CHECK = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_byte_packer.sv
// Packs host bytes little-endian into a 32-bit word; word_full flags the
// accept of the final byte of a word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] byte_idx;

  assign word_full = accept && (byte_idx == LAST_IDX);

  // Shifting in from the top leaves byte 0 in word[7:0] after four accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 1'b1;
      word     <= {byte_data, word[31:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a host byte stream and holds the core in
// reset until the image is complete. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_hold,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte transfers on a rising clk edge where byte_valid && byte_ready;
  // byte_ready depends only on state, never on byte_valid.

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t          state, next_state;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] word_idx;
  logic            start_acc;
  logic            accept;
  logic            word_full;
  logic            last_word;

  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign accept    = byte_valid && (state == LOAD);
  assign last_word = (word_idx + 1'b1) == count_q;
  assign state_dbg = state;

  imem_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc),
    .accept    (accept),
    .byte_data (byte_data),
    .word      (wr_data),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_acc) begin
          if (word_count == '0 || word_count > DEPTH_C) next_state = DONE;
          else                                          next_state = LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (word_full) next_state = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = LOAD;
        end
      end
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state == LOAD) || (state == WRITE) || (state == CHECK);
  assign done      = (state == DONE);
  assign core_hold = !((state == DONE) && !err);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      word_idx <= '0;
      err      <= 1'b0;
      wr_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      if (start_acc) begin
        count_q  <= word_count;
        word_idx <= '0;
        err      <= (word_count > DEPTH_C);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end
      // Address is captured one cycle ahead so it is already valid when wr_en rises.
      if (word_full) wr_addr <= word_idx[ADDR_W-1:0];
      if (state == WRITE) word_idx <= word_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept) sum <= sum + byte_data;
      if (state == CHECK && byte_valid) err <= (byte_data != sum);
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes,
// plus direct checks of status outputs around each load.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_hold;
  logic [2:0]        state_dbg;

  logic [W-1:0] exp_q[$];
  logic [7:0]   img[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int wr_total = 0;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .core_hold(core_hold), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", wr_en, 1'b0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[W-1:32]);
        check("wr_data", wr_data, e[31:0]);
      end
      check("ready_in_write", byte_ready, 1'b0);
      wr_total++;
      last_wr_cyc = cyc;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, byte_ready, 1'b0);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, '0);
    check({tag, "_wr_data"}, wr_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_hold"}, core_hold, 1'b1);
    check({tag, "_state"}, state_dbg, 3'd0);
  endtask

  task automatic start_load(input logic [ADDR_W:0] cnt);
    @(negedge clk);
    start = 1'b1;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", byte_ready, 1'b1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic make_img(input int nwords);
    img.delete();
    for (int i = 0; i < nwords * 4; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_expected(input int nwords);
    for (int w = 0; w < nwords; w++)
      exp_q.push_back({ADDR_W'(w), img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 100);
    check({tag, "_done"}, done, 1'b1);
  endtask

  // Full load of img; gap inserts idle host cycles before each byte,
  // poke pulses a start mid-load, csum_delta corrupts the checksum byte.
  task automatic load_image(input string tag, input int nwords, input int gap,
                            input bit poke, input logic [7:0] csum_delta);
    logic [7:0] sum;
    logic       exp_err;
    sum = '0;
    exp_err = 1'b0;
    push_expected(nwords);
    start_load((ADDR_W + 1)'(nwords));
    check({tag, "_done_clr"}, done, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    for (int i = 0; i < nwords * 4; i++) begin
      send_byte(img[i], gap);
      sum = sum + img[i];
      if (poke && i == 0) begin
        start_load(7'd5);
        check({tag, "_poke_busy"}, busy, 1'b1);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(sum + csum_delta, gap);
    exp_err = (csum_delta != 8'd0);
`endif
    wait_done(tag);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_done_lat"}, 64'(cyc - last_wr_cyc), 64'd1);
`endif
    check({tag, "_err"}, err, exp_err);
    check({tag, "_hold"}, core_hold, exp_err);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Example program from the two-word case
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load_image("basic", 2, 0, 1'b0, 8'd0);

    // Stalling host
    make_img(3);
    load_image("stall", 3, 1, 1'b0, 8'd0);

    // Out-of-range count
    start_load(7'd65);
    check("ovf_done", done, 1'b1);
    check("ovf_err", err, 1'b1);
    check("ovf_hold", core_hold, 1'b1);
    check("ovf_busy", busy, 1'b0);

    // Zero count
    start_load(7'd0);
    check("zero_done", done, 1'b1);
    check("zero_err", err, 1'b0);
    check("zero_hold", core_hold, 1'b0);

    // Reset after 6 bytes of a 3-word load: only word 0 reaches memory
    make_img(3);
    push_expected(1);
    snap = wr_total;
    start_load(7'd3);
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_writes", 64'(wr_total - snap), 64'd1);
    check("abort_q_empty", exp_q.size(), 0);
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    make_img(1);
    load_image("after_abort", 1, 0, 1'b0, 8'd0);

    // Start while busy is ignored; next start reloads from address 0
    make_img(2);
    load_image("poke", 2, 0, 1'b1, 8'd0);
    make_img(2);
    load_image("reload", 2, $urandom_range(0, 2), 1'b0, 8'd0);

    // Full depth
    make_img(DEPTH);
    load_image("full", DEPTH, 0, 1'b0, 8'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{8'h13, 8'h00, 8'h00, 8'h00};
    load_image("csum_ok", 1, 0, 1'b0, 8'd0);
    load_image("csum_bad", 1, 0, 1'b0, 8'd1);
`endif

    repeat (4) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
